seq_bus_datapath: RTL and testbench

//  Parametrised single-bus datapath with a built-in micro-sequencer: NUM_REGS general registers,
//  Y operand latch, Z result register and adder/ALU. It accepts one instruction per valid/ready

---
 rtl/seq_bus_datapath.sv | 200 ++++++++++++++++++++
 tb/tb_seq_bus_datapath.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bus_datapath.sv
// seq_bus_datapath: single-bus register datapath with a T0/T1/T2 micro-sequencer.
// Define DP_SUB_EN to build the subtractor and enable opcode 100 (SUB).
module seq_bus_datapath #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 8,
   parameter int SEL_W    = 3
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [SEL_W-1:0]  in_dst,
   input  logic [SEL_W-1:0]  in_srca,
   input  logic [SEL_W-1:0]  in_srcb,
   input  logic [DATA_W-1:0] in_imm,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] result,
   output logic              flag_z,
   output logic              flag_c,
   input  logic [SEL_W-1:0]  dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_T0,
      S_T1,
      S_T2
   } state_e;

   localparam logic [2:0] OP_LDI  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_MV   = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;

   state_e state_q, state_d;

   logic [2:0]        op_q;
   logic [SEL_W-1:0]  dst_q;
   logic [SEL_W-1:0]  srca_q;
   logic [SEL_W-1:0]  srcb_q;
   logic [DATA_W-1:0] imm_q;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] y_q;
   logic [DATA_W-1:0] z_q;
   logic [DATA_W-1:0] result_q;
   logic              zp_q;
   logic              cp_q;
   logic              flag_z_q;
   logic              flag_c_q;
   logic              done_q;
   logic              err_q;

   logic              accept;
   logic              op_legal;
   logic [DATA_W-1:0] bus;
   logic [DATA_W-1:0] alu_z;
   logic              alu_c;
   logic [DATA_W:0]   sum;

   assign in_ready = (state_q == S_IDLE);
   assign accept   = in_valid && in_ready;
   assign dbg_data = regs_q[dbg_sel];
   assign done     = done_q;
   assign err      = err_q;
   assign result   = result_q;
   assign flag_z   = flag_z_q;
   assign flag_c   = flag_c_q;

   always_comb begin
      op_legal = 1'b0;
      unique case (in_op)
         OP_LDI, OP_ADDI, OP_ADD, OP_MV: op_legal = 1'b1;
`ifdef DP_SUB_EN
         OP_SUB: op_legal = 1'b1;
`endif
         default: op_legal = 1'b0;
      endcase
   end

   // One bus source per step: A in T0, the B operand in T1, Z in T2.
   always_comb begin
      bus = '0;
      unique case (state_q)
         S_T0: bus = regs_q[srca_q];
         S_T1: begin
            unique case (op_q)
               OP_LDI, OP_ADDI: bus = imm_q;
               OP_ADD, OP_SUB:  bus = regs_q[srcb_q];
               default:         bus = '0;
            endcase
         end
         S_T2:    bus = z_q;
         default: bus = '0;
      endcase
   end

   always_comb begin
      alu_z = '0;
      alu_c = 1'b0;
      sum   = '0;
      unique case (op_q)
         OP_LDI: alu_z = bus;
         OP_ADDI, OP_ADD: begin
            sum   = {1'b0, y_q} + {1'b0, bus};
            alu_z = sum[DATA_W-1:0];
            alu_c = sum[DATA_W];
         end
         OP_MV: alu_z = y_q;
`ifdef DP_SUB_EN
         // Carry out of Y + ~B + 1 is the not-borrow flag.
         OP_SUB: begin
            sum   = {1'b0, y_q} + {1'b0, ~bus} + (DATA_W+1)'(1);
            alu_z = sum[DATA_W-1:0];
            alu_c = sum[DATA_W];
         end
`endif
         default: begin
            alu_z = '0;
            alu_c = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept && op_legal) state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1:   state_d = S_T2;
         S_T2:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         op_q   <= '0;
         dst_q  <= '0;
         srca_q <= '0;
         srcb_q <= '0;
         imm_q  <= '0;
      end else if (accept && op_legal) begin
         op_q   <= in_op;
         dst_q  <= in_dst;
         srca_q <= in_srca;
         srcb_q <= in_srcb;
         imm_q  <= in_imm;
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         y_q  <= '0;
         z_q  <= '0;
         zp_q <= 1'b0;
         cp_q <= 1'b0;
      end else begin
         if (state_q == S_T0) y_q <= bus;
         if (state_q == S_T1) begin
            z_q  <= alu_z;
            zp_q <= (alu_z == '0);
            cp_q <= alu_c;
         end
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         result_q <= '0;
         flag_z_q <= 1'b0;
         flag_c_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= (state_q == S_T2);
         err_q  <= accept && !op_legal;
         if (state_q == S_T2) begin
            regs_q[dst_q] <= bus;
            result_q      <= bus;
            flag_z_q      <= zp_q;
            flag_c_q      <= cp_q;
         end
      end
   end

endmodule

// File: tb/tb_seq_bus_datapath.sv
// tb_seq_bus_datapath: directed checks of the sequenced bus datapath.
// Build with or without DP_SUB_EN to cover both opcode-100 behaviours.
module tb_seq_bus_datapath;

   logic        clock;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [2:0]  in_dst;
   logic [2:0]  in_srca;
   logic [2:0]  in_srcb;
   logic [31:0] in_imm;
   logic        done;
   logic        err;
   logic [31:0] result;
   logic        flag_z;
   logic        flag_c;
   logic [2:0]  dbg_sel;
   logic [31:0] dbg_data;

   int n_checks = 0;
   int n_errors = 0;

   seq_bus_datapath dut (
      .clock    (clock),
      .clear    (clear),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_op    (in_op),
      .in_dst   (in_dst),
      .in_srca  (in_srca),
      .in_srcb  (in_srcb),
      .in_imm   (in_imm),
      .done     (done),
      .err      (err),
      .result   (result),
      .flag_z   (flag_z),
      .flag_c   (flag_c),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input logic [2:0] idx, input logic [31:0] exp);
      dbg_sel = idx;
      #1;
      check($sformatf("R%0d", idx), dbg_data, exp);
   endtask

   task automatic drive(input logic [2:0] op, input logic [2:0] d,
                        input logic [2:0] a, input logic [2:0] b,
                        input logic [31:0] imm);
      in_valid = 1'b1;
      in_op    = op;
      in_dst   = d;
      in_srca  = a;
      in_srcb  = b;
      in_imm   = imm;
   endtask

   // Returns at the negedge of the cycle where done should be high.
   task automatic run_op(input logic [2:0] op, input logic [2:0] d,
                         input logic [2:0] a, input logic [2:0] b,
                         input logic [31:0] imm);
      @(negedge clock);
      drive(op, d, a, b, imm);
      check("ready_idle", in_ready, 1);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_op    = 3'b111;
      in_dst   = ~d;
      in_srca  = ~a;
      in_imm   = ~imm;
      @(negedge clock);
      check("ready_t0", in_ready, 0);
      @(negedge clock);
      @(negedge clock);
      check("no_early_done", done, 0);
      @(negedge clock);
      check("done", done, 1);
   endtask

   task automatic run_illegal(input logic [2:0] op);
      @(negedge clock);
      drive(op, 3'd7, 3'd1, 3'd2, 32'h0);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      @(negedge clock);
      check("err_pulse", err, 1);
      check("err_ready", in_ready, 1);
      check("err_no_done", done, 0);
      @(negedge clock);
      check("err_clear", err, 0);
      check("err_ready2", in_ready, 1);
   endtask

   initial begin
      clear    = 1'b1;
      in_valid = 1'b0;
      in_op    = '0;
      in_dst   = '0;
      in_srca  = '0;
      in_srcb  = '0;
      in_imm   = '0;
      dbg_sel  = '0;

      // Asynchronous reset held for 15 ns across a rising edge.
      #2 clear = 1'b0;
      #1;
      check("rst_ready", in_ready, 1);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_result", result, 0);
      check("rst_fz", flag_z, 0);
      check("rst_fc", flag_c, 0);
      for (int i = 0; i < 8; i++) chk_reg(3'(i), 32'h0);
      #6 clear = 1'b1;

      run_op(3'b000, 3'd1, 3'd0, 3'd0, 32'd5);
      check("ldi_result", result, 5);
      chk_reg(3'd1, 32'd5);

      run_op(3'b001, 3'd2, 3'd1, 3'd0, 32'd5);
      check("addi_result", result, 10);
      check("addi_fc", flag_c, 0);
      check("addi_fz", flag_z, 0);
      chk_reg(3'd2, 32'd10);

      run_op(3'b011, 3'd3, 3'd2, 3'd0, 32'd0);
      chk_reg(3'd3, 32'd10);
      check("mv_fc", flag_c, 0);

      run_op(3'b000, 3'd4, 3'd0, 3'd0, 32'hFFFF_FFFF);
      run_op(3'b000, 3'd5, 3'd0, 3'd0, 32'd1);
      run_op(3'b010, 3'd6, 3'd4, 3'd5, 32'd0);
      check("add_wrap", result, 0);
      check("add_fz", flag_z, 1);
      check("add_fc", flag_c, 1);
      chk_reg(3'd6, 32'h0);

      run_op(3'b010, 3'd4, 3'd4, 3'd4, 32'd0);
      chk_reg(3'd4, 32'hFFFF_FFFE);
      check("add_self_fc", flag_c, 1);
      check("add_self_fz", flag_z, 0);

      // Back-to-back: in_valid stays high, fields change right after accept.
      @(negedge clock);
      drive(3'b000, 3'd7, 3'd0, 3'd0, 32'h11);
      @(posedge clock);
      #1;
      drive(3'b001, 3'd0, 3'd7, 3'd0, 32'h1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("b2b_busy1", in_ready, 0);
      end
      @(negedge clock);
      check("b2b_ready", in_ready, 1);
      check("b2b_done1", done, 1);
      chk_reg(3'd7, 32'h11);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("b2b_busy2", in_ready, 0);
      end
      @(negedge clock);
      check("b2b_done2", done, 1);
      chk_reg(3'd0, 32'h12);
      chk_reg(3'd7, 32'h11);

      run_illegal(3'b111);
      chk_reg(3'd7, 32'h11);
      check("ill_result", result, 32'h12);

`ifdef DP_SUB_EN
      run_op(3'b100, 3'd7, 3'd1, 3'd2, 32'd0);
      check("sub_result", result, 32'hFFFF_FFFB);
      check("sub_fc", flag_c, 0);
      check("sub_fz", flag_z, 0);
      chk_reg(3'd7, 32'hFFFF_FFFB);
`else
      run_illegal(3'b100);
      chk_reg(3'd7, 32'h11);
      check("sub_off_result", result, 32'h12);
`endif

      // Reset in T1 of ADDI R2,R1,5 aborts the instruction.
      @(negedge clock);
      drive(3'b001, 3'd2, 3'd1, 3'd0, 32'd5);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      @(posedge clock);
      #2 clear = 1'b0;
      #2 clear = 1'b1;
      chk_reg(3'd2, 32'h0);
      check("abort_ready", in_ready, 1);
      check("abort_result", result, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("abort_no_done", done, 0);
      end
      chk_reg(3'd2, 32'h0);

      run_op(3'b000, 3'd3, 3'd0, 3'd0, 32'h77);
      check("post_rst_result", result, 32'h77);
      chk_reg(3'd3, 32'h77);
      chk_reg(3'd2, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
